alu_sched: RTL and testbench



---
 rtl/alu_sched_pkg.sv | 24 ++
 rtl/alu_rr_arb.sv | 23 ++
 rtl/alu_sched.sv | 130 +++++++++++++
 tb/tb_alu_sched.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sched_pkg.sv
// rtl/alu_sched_pkg.sv - shared types and constants for the two-requester ALU scheduler
package alu_sched_pkg;

  // Number of requesters this revision of the scheduler and arbiter support
  localparam int NREQ_SUPPORTED = 2;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_INC = 3'b010,
    OP_DEC = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_XOR = 3'b110,
    OP_CMP = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_rr_arb.sv
// rtl/alu_rr_arb.sv - combinational 2-way round-robin grant
module alu_rr_arb
  import alu_sched_pkg::*;
(
  input  logic [NREQ_SUPPORTED-1:0] valid,
  input  logic                      ptr,
  input  logic                      en,
  output logic [NREQ_SUPPORTED-1:0] grant
);

  // Favour the requester at ptr; fall back to the other one only if ptr is idle
  always_comb begin
    grant = '0;
    if (en) begin
      if (valid[ptr]) begin
        grant[ptr] = 1'b1;
      end else if (valid[~ptr]) begin
        grant[~ptr] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_sched.sv
// rtl/alu_sched.sv - shares one registered ALU stage between two requesters
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NREQ  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*3-1:0]     req_op,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]      rsp_y,
  output logic                  rsp_c,
  output logic                  busy
);

  generate
    if (NREQ != NREQ_SUPPORTED) begin : g_nreq_check
      $error("alu_sched: NREQ must be 2 in this revision");
    end
    if (WIDTH < 2) begin : g_width_check
      $error("alu_sched: WIDTH must be at least 2");
    end
  endgenerate

  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

  state_e           state;
  logic             ptr;
  logic             id_q;
  alu_op_e          op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [NREQ-1:0]  grant;
  logic             gid;
  logic             accept;
  logic             rsp_fire;
  logic [2:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [NREQ-1:0]  own_onehot;
  logic [WIDTH:0]   res;

  alu_rr_arb u_arb (
    .valid (req_valid),
    .ptr   (ptr),
    .en    (state == ST_IDLE),
    .grant (grant)
  );

  // Grant is only ever non-zero in IDLE, so it doubles as the accept strobe
  assign req_ready = grant;
  assign gid       = grant[1];
  assign accept    = |grant;
  assign rsp_fire  = (state == ST_RESP) && rsp_ready[id_q];
  assign busy      = (state != ST_IDLE);

  assign sel_op = req_op[3*int'(gid) +: 3];
  assign sel_a  = req_a[WIDTH*int'(gid) +: WIDTH];
  assign sel_b  = req_b[WIDTH*int'(gid) +: WIDTH];

  // One-hot routing of the response to whichever requester owns the op
  always_comb begin
    own_onehot       = '0;
    own_onehot[id_q] = 1'b1;
  end

  // ALU evaluated at WIDTH+1 bits so the top bit is carry/borrow
  always_comb begin
    res = '0;
    case (op_q)
      OP_ADD:  res = {1'b0, a_q} + {1'b0, b_q};
      OP_SUB:  res = {1'b0, a_q} - {1'b0, b_q};
      OP_INC:  res = {1'b0, a_q} + ONE;
      OP_DEC:  res = {1'b0, b_q} - ONE;
      OP_AND:  res = {1'b0, a_q & b_q};
      OP_OR:   res = {1'b0, a_q | b_q};
      OP_XOR:  res = {1'b0, a_q ^ b_q};
      OP_CMP:  res = {1'b0, ~a_q};
      default: res = '0;
    endcase
  end

  // IDLE -> EXEC -> RESP sequencer; result registers hold until the owner takes them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ptr       <= 1'b0;
      id_q      <= 1'b0;
      op_q      <= OP_ADD;
      a_q       <= '0;
      b_q       <= '0;
      rsp_valid <= '0;
      rsp_y     <= '0;
      rsp_c     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q  <= alu_op_e'(sel_op);
            a_q   <= sel_a;
            b_q   <= sel_b;
            id_q  <= gid;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_y     <= res[WIDTH-1:0];
          rsp_c     <= res[WIDTH];
          rsp_valid <= own_onehot;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_fire) begin
            rsp_valid <= '0;
            ptr       <= ~id_q;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sched.sv
// tb/tb_alu_sched.sv - directed self-checking bench for alu_sched
module tb_alu_sched;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [5:0]   req_op;
  logic [7:0]   req_a;
  logic [7:0]   req_b;
  logic [1:0]   rsp_valid;
  logic [1:0]   rsp_ready;
  logic [W-1:0] rsp_y;
  logic         rsp_c;
  logic         busy;

  int total = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_sched #(.WIDTH(W), .NREQ(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_y     (rsp_y),
    .rsp_c     (rsp_c),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int r, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    req_op[3*r +: 3] = op;
    req_a[4*r +: 4]  = a;
    req_b[4*r +: 4]  = b;
  endtask

  // Lone requester r issues one op with rsp_ready high; checks accept, latency and result
  task automatic run_lone(input string tag, input int r, input logic [2:0] op,
                          input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] ey, input logic ec);
    set_cmd(r, op, a, b);
    req_valid[r] = 1'b1;
    #1;
    check({tag, ".ready"}, req_ready, 32'(1 << r));
    tick();
    req_valid[r] = 1'b0;
    #1;
    check({tag, ".busy_exec"}, busy, 1);
    check({tag, ".no_rsp_exec"}, rsp_valid, 0);
    tick();
    check({tag, ".rsp_valid"}, rsp_valid, 32'(1 << r));
    check({tag, ".y"}, rsp_y, ey);
    check({tag, ".c"}, rsp_c, ec);
    check({tag, ".busy_resp"}, busy, 1);
    tick();
    check({tag, ".busy_done"}, busy, 0);
    check({tag, ".rsp_done"}, rsp_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [3:0] ey0 [6];
    logic [3:0] ey1 [6];
    logic       ec1 [6];
    logic [3:0] fy  [4];
    logic       fc  [4];
    int c0;
    int c1;
    int exp_r;

    ey0 = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    ey1 = '{4'd14, 4'd15, 4'd0, 4'd1, 4'd2, 4'd3};
    ec1 = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    rst_n     = 1'b0;
    req_valid = 2'b00;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 2'b00;
    #23;
    check("reset.req_ready", req_ready, 0);
    check("reset.rsp_valid", rsp_valid, 0);
    check("reset.rsp_y", rsp_y, 0);
    check("reset.rsp_c", rsp_c, 0);
    check("reset.busy", busy, 0);
    rst_n = 1'b1;
    tick();
    rsp_ready = 2'b11;

    // req0 ADD 9+8 -> y=1 c=1
    run_lone("add", 0, 3'b000, 4'h9, 4'h8, 4'h1, 1'b1);

    // req1 SUB, DEC, CMP
    run_lone("sub", 1, 3'b001, 4'h3, 4'h5, 4'd14, 1'b1);
    run_lone("dec", 1, 3'b011, 4'h7, 4'h0, 4'd15, 1'b1);
    run_lone("cmp", 1, 3'b111, 4'hA, 4'h3, 4'd5, 1'b0);

    // Both valid continuously: req0 ADD k+3, req1 SUB k-2; grants alternate from req0
    c0 = 0;
    c1 = 0;
    set_cmd(0, 3'b000, 4'(c0), 4'd3);
    set_cmd(1, 3'b001, 4'(c1), 4'd2);
    req_valid = 2'b11;
    for (int i = 0; i < 12; i++) begin
      exp_r = i % 2;
      #1;
      check("rr.grant", req_ready, 32'(1 << exp_r));
      tick();
      check("rr.no_ready_exec", req_ready, 0);
      if (exp_r == 0) begin
        c0++;
        set_cmd(0, 3'b000, 4'(c0), 4'd3);
      end else begin
        c1++;
        set_cmd(1, 3'b001, 4'(c1), 4'd2);
      end
      tick();
      check("rr.rsp_route", rsp_valid, 32'(1 << exp_r));
      check("rr.no_ready_resp", req_ready, 0);
      if (exp_r == 0) begin
        check("rr.y0", rsp_y, ey0[c0-1]);
        check("rr.c0", rsp_c, 0);
      end else begin
        check("rr.y1", rsp_y, ey1[c1-1]);
        check("rr.c1", rsp_c, ec1[c1-1]);
      end
      tick();
    end
    req_valid = 2'b00;
    check("rr.count0", c0, 6);
    check("rr.count1", c1, 6);

    // XOR response stalled 5 cycles by rsp_ready[0]; req1 waiting, non-owner ready ignored
    set_cmd(0, 3'b110, 4'hC, 4'hA);
    set_cmd(1, 3'b100, 4'hF, 4'hF);
    rsp_ready = 2'b10;
    req_valid = 2'b11;
    #1;
    check("hold.grant", req_ready, 1);
    tick();
    req_valid = 2'b10;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("hold.rsp_valid", rsp_valid, 1);
      check("hold.y", rsp_y, 6);
      check("hold.c", rsp_c, 0);
      check("hold.no_accept", req_ready, 0);
      check("hold.busy", busy, 1);
      tick();
    end
    rsp_ready = 2'b11;
    #1;
    check("hold.still_valid", rsp_valid, 1);
    tick();
    check("hold.released", rsp_valid, 0);
    check("hold.req1_next", req_ready, 2);
    req_valid = 2'b00;
    #1;
    check("hold.withdrawn", req_ready, 0);

    // Reset during EXEC of INC 0xF: outputs clear immediately, op is lost, ptr back to 0
    set_cmd(0, 3'b010, 4'hF, 4'h0);
    req_valid = 2'b01;
    #1;
    check("rst.grant", req_ready, 1);
    tick();
    req_valid = 2'b00;
    #1;
    check("rst.busy_before", busy, 1);
    check("rst.y_before", rsp_y, 6);
    rst_n = 1'b0;
    #1;
    check("rst.busy", busy, 0);
    check("rst.rsp_y", rsp_y, 0);
    check("rst.rsp_c", rsp_c, 0);
    check("rst.rsp_valid", rsp_valid, 0);
    check("rst.req_ready", req_ready, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst.no_rsp", rsp_valid, 0);
      check("rst.idle", busy, 0);
    end
    set_cmd(0, 3'b100, 4'hC, 4'hA);
    set_cmd(1, 3'b101, 4'h1, 4'h2);
    req_valid = 2'b11;
    #1;
    check("rst.ptr0_wins", req_ready, 1);
    tick();
    req_valid = 2'b00;
    tick();
    check("rst.and_rsp", rsp_valid, 1);
    check("rst.and_y", rsp_y, 8);
    check("rst.and_c", rsp_c, 0);
    tick();

    // Lone req0 back-to-back with valid held; operands scrambled while not ready
    fy = '{4'hF, 4'h0, 4'h0, 4'hF};
    fc = '{1'b0, 1'b1, 1'b0, 1'b0};
    req_valid = 2'b01;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: set_cmd(0, 3'b101, 4'h5, 4'hA);
        1: set_cmd(0, 3'b000, 4'h7, 4'h9);
        2: set_cmd(0, 3'b011, 4'h3, 4'h1);
        default: set_cmd(0, 3'b010, 4'hE, 4'h6);
      endcase
      #1;
      check("b2b.ready", req_ready, 1);
      tick();
      set_cmd(0, 3'b111, 4'(i * 5 + 3), 4'(i + 11));
      #1;
      check("b2b.not_ready1", req_ready, 0);
      tick();
      set_cmd(0, 3'b001, 4'(i + 2), 4'(15 - i));
      #1;
      check("b2b.not_ready2", req_ready, 0);
      check("b2b.rsp", rsp_valid, 1);
      check("b2b.y", rsp_y, fy[i]);
      check("b2b.c", rsp_c, fc[i]);
      tick();
    end
    req_valid = 2'b00;
    #1;
    check("b2b.idle", busy, 0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
